// File: rtl/corr_acc_ntap.sv
// corr_acc_ntap
// -------------
// N-tap I/Q correlation accumulator. Per-tap signed products coming from the
// mixer/PRN multiplier stage are integrated over one code epoch. At the end
// of each epoch the integrated values are dumped into readable registers and
// a dump-ready / IRQ handshake is raised. The dump counter is snapshotted on
// a measurement-fix strobe.
//
// Configuration macro: CORR_ACC_SAT_EN
//   defined   : accumulation clamps to the signed ACC_W range, sat reports
//               whether any clamp happened during the dumped epoch
//   undefined : two's complement wrap modulo 2^ACC_W, sat tied low
//
// Ports:
//   pclk        processing clock
//   resetn      asynchronous active-low reset
//   en          channel enable
//   prod_valid  products valid this cycle
//   prod_i      packed signed I products, tap k at [k*IN_W +: IN_W]
//   prod_q      packed signed Q products, same packing
//   epoch       one-cycle end-of-code strobe
//   fix_pulse   one-cycle measurement-fix strobe
//   rd_tap      readout tap select (out-of-range selects read 0)
//   rd_ack      one-cycle software acknowledge of a dump
//   rd_i/rd_q   dumped I/Q value of the selected tap (combinational mux)
//   dump_rdy    dump valid and not yet acknowledged
//   overrun     sticky: a dump overwrote an unacknowledged dump
//   irq         one-cycle pulse per dump
//   dump_cnt    number of dumps since enable
//   fix_cnt     dump_cnt captured at fix_pulse
//   sat         saturation occurred in the currently dumped epoch

module corr_acc_ntap #(
  parameter int NTAPS = 3,
  parameter int IN_W  = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16,
  localparam int RD_W = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                    pclk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    prod_valid,
  input  logic [NTAPS*IN_W-1:0]   prod_i,
  input  logic [NTAPS*IN_W-1:0]   prod_q,
  input  logic                    epoch,
  input  logic                    fix_pulse,
  input  logic [RD_W-1:0]         rd_tap,
  input  logic                    rd_ack,
  output logic [ACC_W-1:0]        rd_i,
  output logic [ACC_W-1:0]        rd_q,
  output logic                    dump_rdy,
  output logic                    overrun,
  output logic                    irq,
  output logic [CNT_W-1:0]        dump_cnt,
  output logic [CNT_W-1:0]        fix_cnt,
  output logic                    sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef logic [NTAPS-1:0][ACC_W-1:0] tap_vec_t;

  localparam tap_vec_t        TAPS_ZERO = {(NTAPS*ACC_W){1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Sign-extend one product to accumulator width.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [IN_W-1:0] p);
    return {{(ACC_W-IN_W){p[IN_W-1]}}, p};
  endfunction

`ifdef CORR_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamped add; MSB of the result flags that a clamp happened.
  function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                             input logic [IN_W-1:0]  p);
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   raw;
    ext = sext_prod(p);
    raw = {a[ACC_W-1], a} + {ext[ACC_W-1], ext};
    // Overflow when the extra sign bit disagrees with the result sign bit.
    if (raw[ACC_W] != raw[ACC_W-1]) begin
      if (raw[ACC_W]) begin
        return {1'b1, ACC_MIN};
      end else begin
        return {1'b1, ACC_MAX};
      end
    end else begin
      return {1'b0, raw[ACC_W-1:0]};
    end
  endfunction
`else
  // Plain two's complement add, wraps modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] add_wrap(input logic [ACC_W-1:0] a,
                                                input logic [IN_W-1:0]  p);
    return a + sext_prod(p);
  endfunction
`endif

  state_t           state_q, state_d;
  tap_vec_t         acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  tap_vec_t         dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  tap_vec_t         sum_i_s, sum_q_s;
  logic             dump_rdy_q, dump_rdy_d;
  logic             overrun_q, overrun_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] dump_cnt_q, dump_cnt_d;
  logic [CNT_W-1:0] fix_cnt_q, fix_cnt_d;
  logic             dump_s;
  logic [ACC_W-1:0] rd_i_s, rd_q_s;
`ifdef CORR_ACC_SAT_EN
  logic             sat_q, sat_d;
  logic             sat_flag_q, sat_flag_d;
  logic             clamp_s;
  logic [ACC_W:0]   tmp_i_s, tmp_q_s;
`endif

  // Per-tap running sum: accumulator plus this cycle's product when valid.
  always_comb begin
    sum_i_s = acc_i_q;
    sum_q_s = acc_q_q;
`ifdef CORR_ACC_SAT_EN
    clamp_s = 1'b0;
    tmp_i_s = {(ACC_W+1){1'b0}};
    tmp_q_s = {(ACC_W+1){1'b0}};
`endif
    for (int k = 0; k < NTAPS; k++) begin
      if (prod_valid) begin
`ifdef CORR_ACC_SAT_EN
        tmp_i_s    = add_sat(acc_i_q[k], prod_i[k*IN_W +: IN_W]);
        tmp_q_s    = add_sat(acc_q_q[k], prod_q[k*IN_W +: IN_W]);
        sum_i_s[k] = tmp_i_s[ACC_W-1:0];
        sum_q_s[k] = tmp_q_s[ACC_W-1:0];
        clamp_s    = clamp_s | tmp_i_s[ACC_W] | tmp_q_s[ACC_W];
`else
        sum_i_s[k] = add_wrap(acc_i_q[k], prod_i[k*IN_W +: IN_W]);
        sum_q_s[k] = add_wrap(acc_q_q[k], prod_q[k*IN_W +: IN_W]);
`endif
      end else begin
        sum_i_s[k] = acc_i_q[k];
        sum_q_s[k] = acc_q_q[k];
      end
    end
  end

  // FSM next state, accumulator/dump update and handshake bookkeeping.
  always_comb begin
    state_d    = state_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    dump_i_d   = dump_i_q;
    dump_q_d   = dump_q_q;
    dump_rdy_d = dump_rdy_q;
    overrun_d  = overrun_q;
    dump_cnt_d = dump_cnt_q;
    fix_cnt_d  = fix_cnt_q;
    dump_s     = 1'b0;
`ifdef CORR_ACC_SAT_EN
    sat_d      = sat_q;
    sat_flag_d = sat_flag_q;
`endif

    case (state_q)
      ST_IDLE: begin
        acc_i_d = TAPS_ZERO;
        acc_q_d = TAPS_ZERO;
`ifdef CORR_ACC_SAT_EN
        sat_flag_d = 1'b0;
`endif
        if (en) begin
          state_d    = ST_SYNC;
          dump_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Partial first epoch: everything discarded until the first epoch.
      ST_SYNC: begin
        acc_i_d = TAPS_ZERO;
        acc_q_d = TAPS_ZERO;
`ifdef CORR_ACC_SAT_EN
        sat_flag_d = 1'b0;
`endif
        if (!en) begin
          state_d = ST_IDLE;
        end else if (epoch) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          acc_i_d = TAPS_ZERO;
          acc_q_d = TAPS_ZERO;
        end else if (epoch) begin
          // The epoch-cycle product still belongs to the ending epoch.
          dump_s     = 1'b1;
          dump_i_d   = sum_i_s;
          dump_q_d   = sum_q_s;
          acc_i_d    = TAPS_ZERO;
          acc_q_d    = TAPS_ZERO;
          dump_cnt_d = dump_cnt_q + CNT_ONE;
`ifdef CORR_ACC_SAT_EN
          sat_d      = sat_flag_q | clamp_s;
          sat_flag_d = 1'b0;
`endif
        end else begin
          acc_i_d = sum_i_s;
          acc_q_d = sum_q_s;
`ifdef CORR_ACC_SAT_EN
          sat_flag_d = sat_flag_q | clamp_s;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_i_d = TAPS_ZERO;
        acc_q_d = TAPS_ZERO;
      end
    endcase

    // A same-cycle dump wins over the acknowledge for dump_rdy.
    if (dump_s) begin
      dump_rdy_d = 1'b1;
    end else if (rd_ack) begin
      dump_rdy_d = 1'b0;
    end else begin
      dump_rdy_d = dump_rdy_q;
    end

    // An acknowledge in the dump cycle means the old dump was consumed.
    if (rd_ack) begin
      overrun_d = 1'b0;
    end else if (dump_s && dump_rdy_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    // Snapshot the post-update count so a coincident dump is included.
    if (fix_pulse) begin
      fix_cnt_d = dump_cnt_d;
    end else begin
      fix_cnt_d = fix_cnt_q;
    end

    irq_d = dump_s;
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      acc_i_q    <= TAPS_ZERO;
      acc_q_q    <= TAPS_ZERO;
      dump_i_q   <= TAPS_ZERO;
      dump_q_q   <= TAPS_ZERO;
      dump_rdy_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      dump_cnt_q <= CNT_ZERO;
      fix_cnt_q  <= CNT_ZERO;
`ifdef CORR_ACC_SAT_EN
      sat_q      <= 1'b0;
      sat_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      dump_i_q   <= dump_i_d;
      dump_q_q   <= dump_q_d;
      dump_rdy_q <= dump_rdy_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      dump_cnt_q <= dump_cnt_d;
      fix_cnt_q  <= fix_cnt_d;
`ifdef CORR_ACC_SAT_EN
      sat_q      <= sat_d;
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  // Readout mux; selects beyond the last tap read as zero.
  always_comb begin
    if (int'(rd_tap) < NTAPS) begin
      rd_i_s = dump_i_q[rd_tap];
      rd_q_s = dump_q_q[rd_tap];
    end else begin
      rd_i_s = {ACC_W{1'b0}};
      rd_q_s = {ACC_W{1'b0}};
    end
  end

  assign rd_i     = rd_i_s;
  assign rd_q     = rd_q_s;
  assign dump_rdy = dump_rdy_q;
  assign overrun  = overrun_q;
  assign irq      = irq_q;
  assign dump_cnt = dump_cnt_q;
  assign fix_cnt  = fix_cnt_q;
`ifdef CORR_ACC_SAT_EN
  assign sat      = sat_q;
`else
  assign sat      = 1'b0;
`endif

endmodule
